// File: rtl/cs_pkg.sv
// Shared types and constants for the sequential chip-select decoder.
package cs_pkg;

    typedef enum logic [3:0] {
        BANK_RAM0 = 4'h0, BANK_RAM1 = 4'h1, BANK_RAM2 = 4'h2, BANK_RAM3 = 4'h3,
        BANK_ROM  = 4'h4, BANK_IO5  = 4'h5, BANK_RAM6 = 4'h6, BANK_RAM7 = 4'h7,
        BANK_FSB8 = 4'h8, BANK_IO9  = 4'h9, BANK_FSBA = 4'hA, BANK_IOB  = 4'hB,
        BANK_FSBC = 4'hC, BANK_IOD  = 4'hD, BANK_IOE  = 4'hE, BANK_IACK = 4'hF
    } bank_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_TERM   = 2'd2
    } state_e;

    // Bit n set means bank n belongs to that bus domain.
    localparam logic [15:0] FCS_MASK  = 16'h15DF;
    localparam logic [15:0] IOCS_MASK = 16'hEA20;

    localparam logic [3:0] SND_HI_F = 4'hF;
    localparam logic [3:0] SND_HI_A = 4'hA;

    typedef struct packed {
        logic fcs;
        logic iocs;
        logic iacs;
        logic romcs;
        logic ramcs;
        logic vid;
        logic snd;
    } sel_t;

    localparam sel_t SEL_NONE = '0;

    function automatic logic is_snd_page(input logic [3:0] n2, input logic [3:0] n3);
        return ((n2 == SND_HI_F) && (n3 inside {4'hD, 4'hE, 4'hF})) ||
               ((n2 == SND_HI_A) && (n3 inside {4'h1, 4'h2, 4'h3}));
    endfunction

endpackage

// File: rtl/cs_bank_decode.sv
// Combinational map from bank/page nibbles, overlay state and write strobe to the select vector.
module cs_bank_decode
    import cs_pkg::*;
#(
    parameter logic [3:0] VID_PAGE = 4'hF
) (
    input  logic [3:0] bank_i,
    input  logic [3:0] page_i,
    input  logic [3:0] n2_i,
    input  logic [3:0] n3_i,
    input  logic       overlay_i,
    input  logic       nwe_i,
    output logic [6:0] sel_o
);

    bank_e bank;
    sel_t  sel;

    assign bank = bank_e'(bank_i);

    always_comb begin
        // NOTE: every field gets a value before any branch, so no latch can be inferred.
        sel       = SEL_NONE;
        sel.ramcs = ((bank inside {BANK_RAM0, BANK_RAM1, BANK_RAM2, BANK_RAM3}) && !overlay_i) ||
                    ((bank inside {BANK_RAM6, BANK_RAM7}) && overlay_i);
        sel.romcs = (bank == BANK_ROM) || ((bank == BANK_RAM0) && overlay_i);
        sel.fcs   = FCS_MASK[bank_i];
        sel.iacs  = (bank == BANK_IACK);
        sel.vid   = sel.ramcs && (bank inside {BANK_RAM3, BANK_RAM7}) && (page_i == VID_PAGE);
        sel.snd   = sel.vid && is_snd_page(n2_i, n3_i);
        // Video writes are also routed to the IOB so its shadow copy stays coherent.
        sel.iocs  = IOCS_MASK[bank_i] || (sel.vid && !nwe_i);
        sel_o     = sel;
    end

endmodule

// File: rtl/cs_decode_seq.sv
// Bus-cycle latched chip-select decoder with counted overlay release.
// Define CS_BERR_EN to add the bus-error watchdog driving nBERR_o.
module cs_decode_seq
    import cs_pkg::*;
#(
    parameter int         ADDR_W      = 24,
    parameter int         OVL_REL_CNT = 1,
    parameter logic [3:0] VID_PAGE    = 4'hF,
    parameter int         BERR_TMO    = 64
) (
    input  logic              CLK_i,
    input  logic              nRES_i,
    input  logic [ADDR_W-1:0] A_i,
    input  logic              nAS_i,
    input  logic              nWE_i,
    input  logic              nDTACK_i,
    output logic              FCS_o,
    output logic              IOCS_o,
    output logic              IACS_o,
    output logic              ROMCS_o,
    output logic              RAMCS_o,
    output logic              VidRAMCS_o,
    output logic              SndRAMCS_o,
    output logic              Overlay_o,
    output logic              nBERR_o
);

    localparam logic [3:0] REL_CNT = 4'(OVL_REL_CNT);

    state_e     state_q, state_d;
    sel_t       sel_q, sel_d;
    logic [3:0] bank_q, bank_d;
    logic [3:0] cnt_q, cnt_d;
    logic       overlay_q, overlay_d;
    logic [6:0] dec_sel;
    logic       unused_addr;

    assign unused_addr = ^A_i[ADDR_W-17:0];

    cs_bank_decode #(.VID_PAGE(VID_PAGE)) u_decode (
        .bank_i    (A_i[ADDR_W-1 -: 4]),
        .page_i    (A_i[ADDR_W-5 -: 4]),
        .n2_i      (A_i[ADDR_W-9 -: 4]),
        .n3_i      (A_i[ADDR_W-13 -: 4]),
        .overlay_i (overlay_q),
        .nwe_i     (nWE_i),
        .sel_o     (dec_sel)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        bank_d    = bank_q;
        cnt_d     = cnt_q;
        overlay_d = overlay_q;
        case (state_q)
            ST_IDLE: if (!nAS_i) begin
                state_d = ST_ACTIVE;
                sel_d   = sel_t'(dec_sel);
                bank_d  = A_i[ADDR_W-1 -: 4];
            end
            ST_ACTIVE: if (nAS_i) begin
                state_d = ST_TERM;
                sel_d   = SEL_NONE;
                // Only completed ROM-bank cycles count; the counter parks at the release value.
                if ((bank_q == BANK_ROM) && (cnt_q != REL_CNT)) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q + 4'd1 == REL_CNT) overlay_d = 1'b0;
                end
            end
            ST_TERM: state_d = ST_IDLE;
            default: begin
                state_d = ST_IDLE;
                sel_d   = SEL_NONE;
            end
        endcase
    end

    always_ff @(posedge CLK_i or negedge nRES_i) begin
        if (!nRES_i) begin
            state_q   <= ST_IDLE;
            sel_q     <= SEL_NONE;
            bank_q    <= '0;
            cnt_q     <= '0;
            overlay_q <= 1'b1;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q   <= state_d;
            sel_q     <= sel_d;
            bank_q    <= bank_d;
            cnt_q     <= cnt_d;
            overlay_q <= overlay_d;
        end
    end

`ifdef CS_BERR_EN
    localparam logic [7:0] TMO = 8'(BERR_TMO);

    logic [7:0] wd_q, wd_d;
    logic [1:0] age_q, age_d;
    logic       berr_q, berr_d;

    always_comb begin
        wd_d   = wd_q;
        age_d  = age_q;
        berr_d = berr_q;
        case (state_q)
            ST_IDLE: if (!nAS_i) begin
                wd_d   = '0;
                age_d  = '0;
                berr_d = 1'b0;
            end
            ST_ACTIVE: begin
                if (nAS_i) begin
                    berr_d = 1'b0;
                end else begin
                    if (nDTACK_i && (wd_q != 8'hFF)) wd_d = wd_q + 8'd1;
                    if (age_q != 2'd3) age_d = age_q + 2'd1;
                    if (wd_d >= TMO) berr_d = 1'b1;
                    if ((age_d == 2'd2) && !(sel_q.fcs || sel_q.iocs)) berr_d = 1'b1;
                end
            end
            default: berr_d = 1'b0;
        endcase
    end

    always_ff @(posedge CLK_i or negedge nRES_i) begin
        if (!nRES_i) begin
            wd_q   <= '0;
            age_q  <= '0;
            berr_q <= 1'b0;
        end else begin
            wd_q   <= wd_d;
            age_q  <= age_d;
            berr_q <= berr_d;
        end
    end

    assign nBERR_o = ~berr_q;
`else
    logic unused_cfg;
    assign unused_cfg = nDTACK_i ^ (^8'(BERR_TMO));
    assign nBERR_o    = 1'b1;
`endif

    assign FCS_o      = sel_q.fcs;
    assign IOCS_o     = sel_q.iocs;
    assign IACS_o     = sel_q.iacs;
    assign ROMCS_o    = sel_q.romcs;
    assign RAMCS_o    = sel_q.ramcs;
    assign VidRAMCS_o = sel_q.vid;
    assign SndRAMCS_o = sel_q.snd;
    assign Overlay_o  = overlay_q;

endmodule

// File: tb/tb_cs_decode_seq.sv
// Scoreboard bench for cs_decode_seq: driver pushes expected selects, monitor pops and compares.
module tb_cs_decode_seq;

    logic        clk = 1'b0;
    logic        nres;
    logic [23:0] a;
    logic        nas, nwe, ndtack;
    logic        fcs, iocs, iacs, romcs, ramcs, vidcs, sndcs, ovl, nberr;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [6:0] sel;
        logic       ovl;
    } exp_t;

    exp_t sb[$];

    // Reference state: completed ROM-bank cycles since reset; release threshold is 2.
    int   rom_done = 0;
    logic ovl_m    = 1'b1;

    always #5 clk = ~clk;

    cs_decode_seq #(
        .ADDR_W(24), .OVL_REL_CNT(2), .VID_PAGE(4'hF), .BERR_TMO(64)
    ) dut (
        .CLK_i(clk), .nRES_i(nres), .A_i(a), .nAS_i(nas), .nWE_i(nwe), .nDTACK_i(ndtack),
        .FCS_o(fcs), .IOCS_o(iocs), .IACS_o(iacs), .ROMCS_o(romcs), .RAMCS_o(ramcs),
        .VidRAMCS_o(vidcs), .SndRAMCS_o(sndcs), .Overlay_o(ovl), .nBERR_o(nberr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] dut_sel();
        return {fcs, iocs, iacs, romcs, ramcs, vidcs, sndcs};
    endfunction

    // Order of the result: {FCS, IOCS, IACS, ROMCS, RAMCS, VidRAMCS, SndRAMCS}.
    function automatic logic [6:0] model_sel(input logic [23:0] addr, input logic we_n,
                                             input logic ov);
        int b, pg, n2, n3;
        logic f, io, ia, ro, ra, vd, sn;
        b  = int'(addr[23:20]);
        pg = int'(addr[19:16]);
        n2 = int'(addr[15:12]);
        n3 = int'(addr[11:8]);
        ra = ((b <= 3) && !ov) || ((b == 6 || b == 7) && ov);
        ro = (b == 4) || (b == 0 && ov);
        f  = b inside {0, 1, 2, 3, 4, 6, 7, 8, 10, 12};
        ia = (b == 15);
        vd = ra && (b == 3 || b == 7) && (pg == 15);
        sn = vd && ((n2 == 15 && n3 >= 13) || (n2 == 10 && n3 >= 1 && n3 <= 3));
        io = (b inside {5, 9, 11, 13, 14, 15}) || (vd && !we_n);
        return {f, io, ia, ro, ra, vd, sn};
    endfunction

    function automatic void model_reset();
        rom_done = 0;
        ovl_m    = 1'b1;
    endfunction

    function automatic void model_end_cycle(input logic [23:0] addr);
        if (addr[23:20] == 4'h4) rom_done++;
        ovl_m = (rom_done < 2);
    endfunction

    // Monitor: a bus cycle is visible while any select is asserted.
    initial begin
        logic [6:0] cur;
        exp_t       exp_c;
        logic       in_cycle;
        in_cycle    = 1'b0;
        exp_c.sel   = '0;
        exp_c.ovl   = 1'b0;
        forever begin
            @(negedge clk);
            cur = dut_sel();
            if (cur != 7'd0) begin
                if (!in_cycle) begin
                    if (sb.size() == 0) check("unexpected_cycle", 32'(cur), 32'd0);
                    else exp_c = sb.pop_front();
                    in_cycle = 1'b1;
                end
                check("selects", 32'(cur), 32'(exp_c.sel));
                check("overlay_in_cycle", 32'(ovl), 32'(exp_c.ovl));
            end else begin
                in_cycle = 1'b0;
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        nres = 1'b0;
        nas  = 1'b1;
        #1;
        model_reset();
        check("rst_selects", 32'(dut_sel()), 32'd0);
        check("rst_overlay", 32'(ovl), 32'd1);
        check("rst_nberr", 32'(nberr), 32'd1);
        @(negedge clk);
        nres = 1'b1;
    endtask

    // One full bus cycle; when chg >= 0 the address switches to addr2 during ACTIVE.
    task automatic bus_cycle(input logic [23:0] addr, input logic we_n, input int hold,
                             input logic [23:0] addr2, input int chg);
        exp_t e;
        @(negedge clk);
        a    = addr;
        nwe  = we_n;
        nas  = 1'b0;
        e.sel = model_sel(addr, we_n, ovl_m);
        e.ovl = ovl_m;
        sb.push_back(e);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (i == chg) a = addr2;
        end
        nas = 1'b1;
        @(posedge clk);
        model_end_cycle(addr);
        @(negedge clk);
        check("term_selects", 32'(dut_sel()), 32'd0);
        check("term_overlay", 32'(ovl), 32'(ovl_m));
        check("term_nberr", 32'(nberr), 32'd1);
    endtask

    function automatic logic [23:0] rand_addr();
        logic [3:0] b, pg, n2, n3;
        logic [7:0] lo;
        b  = 4'($urandom_range(0, 15));
        pg = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
        case ($urandom_range(0, 2))
            0:       n2 = 4'hF;
            1:       n2 = 4'hA;
            default: n2 = 4'($urandom_range(0, 15));
        endcase
        n3 = 4'($urandom_range(0, 15));
        lo = 8'($urandom_range(0, 255));
        return {b, pg, n2, n3, lo};
    endfunction

`ifdef CS_BERR_EN
    task automatic berr_cycles();
        exp_t e;
        int   first_low;
        logic seen_low;
        @(negedge clk);
        a = 24'h800000; nwe = 1'b1; nas = 1'b0; ndtack = 1'b1;
        e.sel = model_sel(a, 1'b1, ovl_m); e.ovl = ovl_m;
        sb.push_back(e);
        first_low = -1;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (!nberr && first_low < 0) first_low = k;
        end
        check("berr_timeout_cycle", 32'(first_low), 32'd64);
        nas = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("berr_release_term", 32'(nberr), 32'd1);
        @(negedge clk);
        a = 24'h800000; nas = 1'b0; ndtack = 1'b1;
        e.sel = model_sel(a, 1'b1, ovl_m); e.ovl = ovl_m;
        sb.push_back(e);
        seen_low = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (k == 2) ndtack = 1'b0;
            if (!nberr) seen_low = 1'b1;
        end
        check("berr_acked_cycle", 32'(seen_low), 32'd0);
        nas = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask
`endif

    initial begin
        exp_t e;
        nres = 1'b0; nas = 1'b1; nwe = 1'b1; ndtack = 1'b0; a = '0;
        apply_reset();

        // Overlay active: low RAM address maps to ROM.
        bus_cycle(24'h000100, 1'b1, 2, 24'h0, -1);
        // Two ROM-bank cycles release the overlay at the end of the second.
        bus_cycle(24'h400000, 1'b1, 1, 24'h0, -1);
        check("ovl_after_first_rom", 32'(ovl), 32'd1);
        bus_cycle(24'h400000, 1'b1, 3, 24'h0, -1);
        check("ovl_after_second_rom", 32'(ovl), 32'd0);
        bus_cycle(24'h000100, 1'b1, 2, 24'h0, -1);
        // Video/sound page write then read.
        bus_cycle(24'h3FFD00, 1'b0, 2, 24'h0, -1);
        bus_cycle(24'h3FFD00, 1'b1, 2, 24'h0, -1);
        // Address change during ACTIVE is ignored.
        bus_cycle(24'h100000, 1'b1, 4, 24'h500000, 1);

`ifdef CS_BERR_EN
        berr_cycles();
`endif

        // Reset mid-cycle discards the partial ROM count.
        apply_reset();
        bus_cycle(24'h400000, 1'b1, 1, 24'h0, -1);
        @(negedge clk);
        a = 24'h400000; nwe = 1'b1; nas = 1'b0;
        e.sel = model_sel(a, 1'b1, ovl_m); e.ovl = ovl_m;
        sb.push_back(e);
        @(negedge clk);
        @(negedge clk);
        #2 nres = 1'b0;
        #1;
        model_reset();
        check("midrst_selects", 32'(dut_sel()), 32'd0);
        check("midrst_overlay", 32'(ovl), 32'd1);
        nas = 1'b1;
        @(negedge clk);
        nres = 1'b1;
        bus_cycle(24'h400000, 1'b1, 2, 24'h0, -1);
        check("ovl_single_after_rst", 32'(ovl), 32'd1);

        // Random traffic against the reference model.
        for (int n = 0; n < 60; n++) begin
            int h, c;
            h = $urandom_range(1, 4);
            c = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, h - 1)) : -1;
            bus_cycle(rand_addr(), 1'($urandom_range(0, 1)), h, rand_addr(), c);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cs_decode_seq.md
Name: cs_decode_seq

Overview:
Sequential successor to the fixed 24-bit chip-select decoder. It decodes the high-order address into FSB/IOB domain selects and device selects, and latches them for the whole bus cycle (nAS-qualified). Overlay release is parametrised: it occurs after a configurable number of ROM-region cycles rather than on the first. An optional watchdog asserts bus error on cycles that go unacknowledged or hit unmapped space. The block sits between the CPU address/strobe pins and the FSB/IOB bus controllers.

Parameters:
ADDR_W, 24, CPU address width; decode uses bank field A[ADDR_W-1:ADDR_W-4] (16 banks).
OVL_REL_CNT, 1, number of completed ROM-bank (bank 4) cycles before overlay clears; range 1..15.
VID_PAGE, 4'hF, A[ADDR_W-5:ADDR_W-8] value selecting the video/sound page inside RAM banks 3/7.
BERR_TMO, 64, watchdog limit in CLK cycles (used only with CS_BERR_EN).

Ports:
CLK  in  1  system clock
nRES  in  1  asynchronous active-low reset
A  in  ADDR_W  CPU address
nAS  in  1  CPU address strobe, active low, already synchronous to CLK
nWE  in  1  write strobe, active low
nDTACK  in  1  cycle acknowledge from bus controllers, active low
FCS  out  1  FSB domain select
IOCS  out  1  IOB domain select
IACS  out  1  interrupt-acknowledge select (bank F)
ROMCS  out  1  ROM select
RAMCS  out  1  RAM select
VidRAMCS  out  1  video RAM page select
SndRAMCS  out  1  sound buffer select
Overlay  out  1  current overlay state
nBERR  out  1  bus error to CPU, active low

Behaviour:
- Reset (nRES low, async): all selects 0, Overlay=1, nBERR=1, release counter 0, FSM IDLE.
- Bank map (b = bank field): RAM = b in {0,1,2,3} with Overlay=0, or b in {6,7} with Overlay=1. ROM = b==4, or b==0 with Overlay=1. FCS = b in {0,1,2,3,4,6,7,8,A,C}. IACS = b==F. IOCS = b in {5,9,B,D,E,F}, or (VidRAMCS && nWE==0). Banks 8, A, C assert FCS only.
- VidRAMCS = RAMCS && b in {3,7} && A[ADDR_W-5:ADDR_W-8]==VID_PAGE. SndRAMCS = VidRAMCS && (next nibble F with following nibble D/E/F, or next nibble A with following nibble 1/2/3).
- FSM states: IDLE, ACTIVE, TERM.
  - IDLE -> ACTIVE on the first CLK edge where nAS=0. On that edge the decode is evaluated from A/nWE and registered. Selects are valid 1 CLK after nAS is sampled low.
  - ACTIVE: selects hold; address changes are ignored. ACTIVE -> TERM when nAS is sampled high.
  - TERM: all selects 0 for one cycle, then IDLE. A new nAS=0 sampled in TERM is handled on the next IDLE cycle; there is no back-to-back latch.
- Overlay release: a ROM-bank cycle (b==4) increments the counter on its ACTIVE->TERM transition. When the count reaches OVL_REL_CNT, Overlay clears on that same edge. Overlay stays 0 until reset; the counter saturates.
  - The decode of the cycle that triggers release uses the old Overlay value.
- Reset mid-cycle: everything returns to reset values immediately; the aborted cycle does not count.
- Without CS_BERR_EN, nBERR is tied to 1.

Optional Feature:
CS_BERR_EN.
- With the macro: an 8-bit watchdog clears on entry to ACTIVE and increments each ACTIVE cycle while nDTACK=1.
  - nBERR goes low when the count reaches BERR_TMO, or 2 cycles into ACTIVE if the latched bank asserts neither FCS nor IOCS.
  - nBERR stays low until nAS is sampled high, then goes high in TERM.
  - A cycle that ends in bus error still counts toward overlay release if it is a ROM-bank cycle.
- Without the macro: no counter, nBERR=1 constant, and the nDTACK input is unused.

Decomposition:
- Package cs_pkg: bank enum (BANK_RAM0..BANK_IACK, 4-bit), FSM state enum, FCS/IOCS bank mask constants (16'h15DF and 16'hEA20), sound-buffer nibble constants.
- One sub-module, cs_bank_decode: purely combinational map from (bank, page nibbles, Overlay, nWE) to the select vector. The parent holds the FSM, registers, overlay counter and watchdog.

Test Plan:
- Reset, then a cycle with A=24'h000100 and nAS low: ROMCS=1, FCS=1, RAMCS=0 one CLK after nAS sampled low; Overlay=1.
- OVL_REL_CNT=2: two bank-4 cycles -> Overlay stays 1 after the first and drops at the end of the second. A following A=24'h000100 cycle -> RAMCS=1, ROMCS=0.
- Overlay=0, write to A=24'h3FFD00 -> RAMCS, VidRAMCS, SndRAMCS, FCS and IOCS all 1. The same address as a read -> IOCS=0.
- Change A from 24'h100000 to 24'h500000 mid-ACTIVE -> RAMCS stays 1, IOCS stays 0. One TERM cycle with all selects 0 follows nAS high.
- With CS_BERR_EN and BERR_TMO=64, cycle to A=24'h800000 with nDTACK held high -> nBERR=0 on cycle 64 of ACTIVE, released in TERM. A cycle with nDTACK low at cycle 3 -> nBERR stays 1.
- nRES pulsed low during an ACTIVE bank-4 cycle with count=1 -> selects 0 and Overlay=1 immediately. The next bank-4 cycle alone does not release when OVL_REL_CNT=2.
